// File: rtl/beam_scan_controller_pkg.sv
// rtl/beam_scan_controller_pkg.sv - shared types and constants for the beam scan controller
package beam_scan_controller_pkg;

  localparam int BF_IDX_W  = 16;
  localparam int BF_DATA_W = 32;
  localparam logic [BF_IDX_W-1:0] BF_IDX_IDLE = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_EMIT,
    ST_DONE
  } bsc_state_e;

endpackage

// File: rtl/bsc_addr_pipe.sv
// rtl/bsc_addr_pipe.sv - delays issued RAM addresses plus a valid bit to line up with read data
module bsc_addr_pipe #(
  parameter int AW    = 10,
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [AW-1:0] addr_i,
  input  logic          valid_i,
  output logic [AW-1:0] addr_o,
  output logic          valid_o
);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      addr_q[0] <= addr_i;
      vld_q[0]  <= valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        addr_q[i] <= addr_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign addr_o  = addr_q[DEPTH-1];
  assign valid_o = vld_q[DEPTH-1];

endmodule

// File: rtl/beam_scan_controller.sv
// rtl/beam_scan_controller.sv - replays sample RAM into the beamformer once per beam and sums its taps
module beam_scan_controller
  import beam_scan_controller_pkg::*;
#(
  parameter int NUM_SAMPLES   = 1024,
  parameter int NUM_BEAMS     = 8,
  parameter int TAPS_PER_BEAM = 16,
  parameter int RAM_LATENCY   = 2,
  parameter int ACC_W         = 40
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [$clog2(NUM_SAMPLES)-1:0] sample_addr_o,
  output logic                          sample_rden_o,
  input  logic [BF_DATA_W-1:0]          sample_q_i,
  output logic [BF_DATA_W-1:0]          bf_input_value_o,
  output logic [BF_IDX_W-1:0]           bf_input_index_o,
  output logic                          bf_start_o,
  input  logic [BF_DATA_W-1:0]          bf_output_value_i,
  input  logic                          bf_data_good_i,
  output logic [ACC_W-1:0]              beam_sum_o,
  output logic [7:0]                    beam_id_o,
  output logic                          beam_valid_o,
  output logic                          tap_err_o
);

  localparam int AW        = $clog2(NUM_SAMPLES);
  localparam int DRAIN_CYC = RAM_LATENCY + 2;

  bsc_state_e       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [7:0]       drain_q, drain_d;
  logic [7:0]       beam_q, beam_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_upd;
  logic [7:0]       tap_q, tap_d, tap_upd;
  logic [ACC_W-1:0] beam_sum_q, beam_sum_d;
  logic [7:0]       beam_id_q, beam_id_d;
  logic             tap_err_q, tap_err_d;
  logic [BF_DATA_W-1:0] bf_val_q;
  logic [BF_IDX_W-1:0]  bf_idx_q;
  logic [AW-1:0]    pipe_addr;
  logic             pipe_vld;
  logic             accum_en;

  bsc_addr_pipe #(.AW(AW), .DEPTH(RAM_LATENCY)) u_addr_pipe (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .addr_i  (addr_q),
    .valid_i (sample_rden_o),
    .addr_o  (pipe_addr),
    .valid_o (pipe_vld)
  );

  assign busy_o           = (state_q != ST_IDLE);
  assign done_o           = (state_q == ST_DONE);
  assign sample_rden_o    = (state_q == ST_STREAM);
  assign sample_addr_o    = addr_q;
  assign bf_start_o       = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign beam_valid_o     = (state_q == ST_EMIT);
  assign beam_sum_o       = beam_sum_q;
  assign beam_id_o        = beam_id_q;
  assign tap_err_o        = tap_err_q;
  assign bf_input_value_o = bf_val_q;
  assign bf_input_index_o = bf_idx_q;

  // Taps only count while a pass is in flight; EMIT/DONE/IDLE pulses are stray.
  assign accum_en = bf_data_good_i && bf_start_o;

  always_comb begin
    acc_upd = acc_q;
    tap_upd = tap_q;
    if (accum_en) begin
      acc_upd = acc_q + {{(ACC_W-BF_DATA_W){bf_output_value_i[BF_DATA_W-1]}}, bf_output_value_i};
      tap_upd = (tap_q == 8'hFF) ? tap_q : tap_q + 8'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    drain_d    = drain_q;
    beam_d     = beam_q;
    acc_d      = acc_upd;
    tap_d      = tap_upd;
    beam_sum_d = beam_sum_q;
    beam_id_d  = beam_id_q;
    tap_err_d  = tap_err_q;
    case (state_q)
      ST_IDLE: begin
        addr_d  = '0;
        drain_d = '0;
        beam_d  = '0;
        if (start_i) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (addr_q == AW'(NUM_SAMPLES-1)) begin
          addr_d  = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Result is latched on the final drain cycle so a tap landing in it is still counted.
        if (drain_q == 8'(DRAIN_CYC-1)) begin
          beam_sum_d = acc_upd;
          tap_err_d  = (tap_upd != 8'(TAPS_PER_BEAM));
          beam_id_d  = beam_q;
          acc_d      = '0;
          tap_d      = '0;
          state_d    = ST_EMIT;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      ST_EMIT: begin
        if (beam_q == 8'(NUM_BEAMS-1)) begin
          beam_d  = '0;
          state_d = ST_DONE;
        end else begin
          beam_d  = beam_q + 8'd1;
          state_d = ST_STREAM;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      drain_q    <= '0;
      beam_q     <= '0;
      acc_q      <= '0;
      tap_q      <= '0;
      beam_sum_q <= '0;
      beam_id_q  <= '0;
      tap_err_q  <= 1'b0;
      bf_val_q   <= '0;
      bf_idx_q   <= BF_IDX_IDLE;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      beam_q     <= beam_d;
      acc_q      <= acc_d;
      tap_q      <= tap_d;
      beam_sum_q <= beam_sum_d;
      beam_id_q  <= beam_id_d;
      tap_err_q  <= tap_err_d;
      if (pipe_vld) begin
        bf_val_q <= sample_q_i;
        bf_idx_q <= BF_IDX_W'(pipe_addr);
      end else begin
        bf_idx_q <= BF_IDX_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_beam_scan_controller.sv
// tb/tb_beam_scan_controller.sv - self-checking bench for beam_scan_controller
module tb_beam_scan_controller;

  localparam int NS = 1024, NB = 3, TAPS = 4, LAT = 2, ACCW = 40;
  localparam int FRAME_CYC = NB * (NS + LAT + 3) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_i, start_i, busy_o, done_o, sample_rden_o;
  logic [9:0]      sample_addr_o;
  logic [31:0]     sample_q_i, bf_input_value_o, bf_output_value_i;
  logic [15:0]     bf_input_index_o;
  logic            bf_start_o, bf_data_good_i, beam_valid_o, tap_err_o;
  logic [ACCW-1:0] beam_sum_o;
  logic [7:0]      beam_id_o;

  beam_scan_controller #(
    .NUM_SAMPLES(NS), .NUM_BEAMS(NB), .TAPS_PER_BEAM(TAPS), .RAM_LATENCY(LAT), .ACC_W(ACCW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .sample_addr_o(sample_addr_o), .sample_rden_o(sample_rden_o), .sample_q_i(sample_q_i),
    .bf_input_value_o(bf_input_value_o), .bf_input_index_o(bf_input_index_o),
    .bf_start_o(bf_start_o), .bf_output_value_i(bf_output_value_i),
    .bf_data_good_i(bf_data_good_i), .beam_sum_o(beam_sum_o), .beam_id_o(beam_id_o),
    .beam_valid_o(beam_valid_o), .tap_err_o(tap_err_o)
  );

  int errors = 0, checks = 0;
  logic [31:0]     mem [NS];
  int              tbl [NB][8];
  int              ntap [NB];
  logic [ACCW-1:0] exp_sum [NB];
  logic            exp_err [NB];
  logic [31:0]     ram_r1;
  int              bm_beam;

  // Sample RAM: two-cycle read latency
  always @(posedge clk) begin
    if (sample_rden_o) ram_r1 <= mem[sample_addr_o];
    sample_q_i <= ram_r1;
  end

  function automatic logic tap_hit(input int b, input logic [15:0] idx);
    for (int j = 0; j < ntap[b]; j++)
      if (tbl[b][j] == int'(idx)) return 1'b1;
    return 1'b0;
  endfunction

  // Beamformer: one registered output cycle per matching delay index
  always @(posedge clk) begin
    if (reset_i || done_o) begin
      bm_beam        <= 0;
      bf_data_good_i <= 1'b0;
    end else begin
      bf_data_good_i    <= bf_start_o && tap_hit(bm_beam, bf_input_index_o);
      bf_output_value_i <= bf_input_value_o;
      if (beam_valid_o && bm_beam < NB - 1) bm_beam <= bm_beam + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void compute_expect();
    for (int b = 0; b < NB; b++) begin
      logic signed [ACCW-1:0] s;
      s = '0;
      for (int j = 0; j < ntap[b]; j++) s = s + ACCW'($signed(mem[tbl[b][j]]));
      exp_sum[b] = s;
      exp_err[b] = (ntap[b] != TAPS);
    end
  endfunction

  task automatic run_frame(input bit hold);
    int cyc, nv, done_cyc, low, nrd, bad_addr, exp_a;
    bit seen_done;
    start_i = 1'b1;
    cyc = 0; nv = 0; low = 0; nrd = 0; bad_addr = 0; exp_a = 0;
    done_cyc = -1; seen_done = 0;
    while (!seen_done && cyc < FRAME_CYC + 50) begin
      @(negedge clk);
      cyc++;
      start_i = hold;
      if (cyc == 1) begin
        chk("first_busy", busy_o, 1);
        chk("first_addr", sample_addr_o, 0);
      end
      if (sample_rden_o) begin
        nrd++;
        if (int'(sample_addr_o) != exp_a) bad_addr++;
        exp_a = (exp_a + 1) % NS;
      end
      if (beam_valid_o) begin
        if (nv < NB) begin
          chk("beam_sum", beam_sum_o, exp_sum[nv]);
          chk("beam_id", beam_id_o, nv);
          chk("tap_err", tap_err_o, exp_err[nv]);
          chk("bf_start_in_emit", bf_start_o, 0);
        end
        nv++;
      end
      if (busy_o && !bf_start_o && !done_o) low++;
      if (done_o) begin
        seen_done = 1;
        done_cyc  = cyc;
      end
    end
    chk("done_cycle", done_cyc, FRAME_CYC);
    chk("beam_count", nv, NB);
    chk("bf_start_low_cycles", low, NB);
    chk("rden_cycles", nrd, NB * NS);
    chk("addr_seq_errs", bad_addr, 0);
    @(negedge clk);
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_o, 0);
    chk("idle_index", bf_input_index_o, 16'hFFFF);
    chk("sum_hold", beam_sum_o, exp_sum[NB-1]);
    start_i = hold;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_rden_addr"}, {sample_rden_o, sample_addr_o}, 0);
    chk({tag, "_bf_start"}, bf_start_o, 0);
    chk({tag, "_bf_value"}, bf_input_value_o, 0);
    chk({tag, "_bf_index"}, bf_input_index_o, 16'hFFFF);
    chk({tag, "_beam_out"}, {beam_sum_o, beam_id_o, beam_valid_o, tap_err_o}, 0);
  endtask

  typedef struct {
    int              mode;
    int              n;
    int              idx [6];
    logic [ACCW-1:0] sum;
    logic            err;
  } vec_t;

  vec_t vecs [5];

  task automatic load_vec(input int v);
    for (int i = 0; i < NS; i++)
      mem[i] = (vecs[v].mode == 0) ? 32'(i * 3) : 32'h8000_0000;
    for (int b = 0; b < NB; b++) begin
      ntap[b] = vecs[v].n;
      for (int j = 0; j < 6; j++) tbl[b][j] = vecs[v].idx[j];
      exp_sum[b] = vecs[v].sum;
      exp_err[b] = vecs[v].err;
    end
  endtask

  initial begin
    int cnt, ndone, nbusy;
    vecs[0] = '{0, 4, '{5, 40, 41, 900, 0, 0},    40'd2958,         1'b0};
    vecs[1] = '{0, 4, '{5, 40, 41, 1023, 0, 0},   40'd3327,         1'b0};
    vecs[2] = '{1, 4, '{5, 40, 41, 900, 0, 0},    40'hFE_0000_0000, 1'b0};
    vecs[3] = '{1, 5, '{5, 40, 41, 900, 1023, 0}, 40'hFD_8000_0000, 1'b1};
    vecs[4] = '{0, 3, '{0, 512, 1023, 0, 0, 0},   40'd4605,         1'b1};

    reset_i = 1'b1;
    start_i = 1'b0;
    load_vec(0);
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset_i = 1'b0;

    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      run_frame(1'b0);
    end

    // Abort mid-STREAM of beam 1
    load_vec(0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cnt = 0;
    while (!beam_valid_o && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    chk("abort_reached_beam1", cnt < 2000, 1);
    repeat (100) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    chk_reset_state("abort");
    reset_i = 1'b0;
    ndone = 0; nbusy = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) ndone++;
      if (busy_o) nbusy++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_no_busy", nbusy, 0);
    run_frame(1'b0);

    // Start held high: back-to-back frames
    load_vec(1);
    run_frame(1'b1);
    run_frame(1'b1);
    start_i = 1'b0;

    // Random RAM contents and random delay tables
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NS; i++) mem[i] = $urandom;
      for (int b = 0; b < NB; b++) begin
        ntap[b] = int'($urandom_range(3, 5));
        for (int j = 0; j < ntap[b]; j++)
          tbl[b][j] = j * (NS / ntap[b]) + int'($urandom_range(0, NS / ntap[b] - 1));
      end
      compute_expect();
      run_frame(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
